// File: rtl/rega_ctrl_if.sv
// Sensor inputs and irrigation request outputs of rega_ctrl.
// master drives the sensors; slave is the request generator.
interface rega_ctrl_if;
  logic [1:0] umid;
  logic [1:0] nivel;
  logic [1:0] rega;
  logic       alarme;
  logic [7:0] n_regas;

  modport master (
    output umid,
    output nivel,
    input  rega,
    input  alarme,
    input  n_regas
  );

  modport slave (
    input  umid,
    input  nivel,
    output rega,
    output alarme,
    output n_regas
  );
endinterface

// File: rtl/rega_ctrl.sv
// Irrigation request generator: synchronizes and debounces the moisture/level
// sensors, enforces a minimum on-time and locks out on an empty tank.
module rega_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_ON     = 8
) (
  input  logic        CLK,
  input  logic        reset,
  rega_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int OW = $clog2(MIN_ON + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
  localparam logic [OW-1:0] ON_MAX  = OW'(MIN_ON);

  // Non-VAZIO candidates share bits [1:0] with the matching state encoding.
  typedef enum logic [1:0] {
    C_NADA  = 2'b00,
    C_GOT   = 2'b01,
    C_ASP   = 2'b10,
    C_VAZIO = 2'b11
  } cand_t;

  typedef enum logic [2:0] {
    S_NADA  = 3'b000,
    S_GOT   = 3'b001,
    S_ASP   = 3'b010,
    S_TRAVA = 3'b100
  } state_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [1:0]    umid_s, nivel_s;
  cand_t         cand;
  cand_t         cand_q, cand_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          stable;
  state_t        state_q, state_d;
  logic [OW-1:0] on_cnt_q, on_cnt_d;
  logic [7:0]    n_regas_q, n_regas_d;
  logic [1:0]    rega_q, rega_d;
  logic          alarme_q, alarme_d;
  logic          in_irrig, entering, legal_state;

  // Sensor bits packed as {umid, nivel}; reset value reads as wet soil, full tank.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= {bus.umid, bus.nivel};
      sync2_q <= sync1_q;
    end
  end

  assign umid_s  = sync2_q[3:2];
  assign nivel_s = sync2_q[1:0];

  always_comb begin
    cand = C_NADA;
    if (nivel_s == 2'b00) begin
      cand = C_VAZIO;
    end else if (umid_s == 2'b00 && nivel_s[1]) begin
      cand = C_ASP;
    end else if (umid_s == 2'b00 || umid_s == 2'b01) begin
      cand = C_GOT;
    end
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (cand != cand_q) begin
      cand_d = cand;
      cnt_d  = DW'(1);
    end else if (cnt_q < DEB_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable      = (cnt_q == DEB_MAX);
  assign in_irrig    = (state_q == S_ASP) || (state_q == S_GOT);
  assign legal_state = (state_q == S_NADA) || (state_q == S_ASP) ||
                       (state_q == S_GOT)  || (state_q == S_TRAVA);

  always_comb begin
    state_d = state_q;
    if (!legal_state) begin
      state_d = S_NADA;
    end else if (nivel_s == 2'b00) begin
      state_d = S_TRAVA;
    end else begin
      case (state_q)
        S_TRAVA: begin
          if (stable && cand_q != C_VAZIO) state_d = S_NADA;
        end
        S_NADA: begin
          if (stable && (cand_q == C_ASP || cand_q == C_GOT))
            state_d = state_t'({1'b0, cand_q});
        end
        S_ASP, S_GOT: begin
          // An early debounced change waits here until the on-time saturates.
          if (stable && cand_q != C_VAZIO && cand_q != state_q[1:0] &&
              on_cnt_q == ON_MAX)
            state_d = state_t'({1'b0, cand_q});
        end
        default: state_d = S_NADA;
      endcase
    end
  end

  assign entering = ((state_d == S_ASP) || (state_d == S_GOT)) && (state_d != state_q);

  always_comb begin
    on_cnt_d  = on_cnt_q;
    n_regas_d = n_regas_q + {7'd0, entering};
    if (entering) begin
      on_cnt_d = '0;
    end else if (in_irrig && on_cnt_q < ON_MAX) begin
      on_cnt_d = on_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rega_d   = 2'b00;
    alarme_d = 1'b0;
    case (state_d)
      S_ASP:   rega_d   = 2'b10;
      S_GOT:   rega_d   = 2'b01;
      S_TRAVA: alarme_d = 1'b1;
      default: rega_d   = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cand_q    <= C_NADA;
      cnt_q     <= '0;
      state_q   <= S_NADA;
      on_cnt_q  <= '0;
      n_regas_q <= 8'd0;
      rega_q    <= 2'b00;
      alarme_q  <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      n_regas_q <= n_regas_d;
      rega_q    <= rega_d;
      alarme_q  <= alarme_d;
    end
  end

  assign bus.rega    = rega_q;
  assign bus.alarme  = alarme_q;
  assign bus.n_regas = n_regas_q;

endmodule

// File: tb/tb_rega_ctrl.sv
// Bench for rega_ctrl: vector table, directed corner sequences and random
// stimulus, all compared against a history-based reference model.
module tb_rega_ctrl;
  localparam int DEB   = 4;
  localparam int MINON = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rega_ctrl_if bus();

  rega_ctrl #(.DEB_CYCLES(DEB), .MIN_ON(MINON)) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model codes: state 0 NADA, 1 ASP, 2 GOT, 3 TRAVA; candidate 3 = VAZIO.
  int in_hist[$];
  int cand_hist[$];
  int m_state, m_entry, m_edge, m_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cand_of(input int s);
    int u, n;
    u = (s >> 2) & 3;
    n = s & 3;
    if (n == 0) return 3;
    if (u == 0 && n >= 2) return 1;
    if (u == 0) return 2;
    if (u == 1) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] exp_rega();
    return (m_state == 1) ? 2'b10 : (m_state == 2) ? 2'b01 : 2'b00;
  endfunction

  task automatic model_reset();
    in_hist.delete();
    cand_hist.delete();
    m_state = 0;
    m_entry = 0;
    m_edge  = 0;
    m_n     = 0;
  endtask

  task automatic model_edge(input int in_now);
    int s2, c, cq, nxt;
    bit stable;
    m_edge++;
    s2 = (in_hist.size() >= 2) ? in_hist[in_hist.size()-2] : 15;
    c  = cand_of(s2);
    cq = (cand_hist.size() > 0) ? cand_hist[cand_hist.size()-1] : 0;
    stable = (cand_hist.size() >= DEB);
    for (int k = 1; k <= DEB && stable; k++)
      if (cand_hist[cand_hist.size()-k] != cq) stable = 0;
    nxt = m_state;
    if ((s2 & 3) == 0) nxt = 3;
    else if (m_state == 3) begin
      if (stable && cq != 3) nxt = 0;
    end else if (m_state == 0) begin
      if (stable && (cq == 1 || cq == 2)) nxt = cq;
    end else begin
      if (stable && cq != 3 && cq != m_state && (m_edge - 1 - m_entry) >= MINON) nxt = cq;
    end
    if ((nxt == 1 || nxt == 2) && nxt != m_state) begin
      m_entry = m_edge;
      m_n = (m_n + 1) % 256;
    end
    m_state = nxt;
    in_hist.push_back(in_now);
    cand_hist.push_back(c);
    while (in_hist.size() > 2) void'(in_hist.pop_front());
    while (cand_hist.size() > DEB) void'(cand_hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge({28'd0, bus.umid, bus.nivel});
    #1;
    check("model.rega", {30'd0, bus.rega}, {30'd0, exp_rega()});
    check("model.alarme", {31'd0, bus.alarme}, (m_state == 3) ? 1 : 0);
    check("model.n_regas", {24'd0, bus.n_regas}, m_n);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_in(input logic [1:0] u, input logic [1:0] n);
    bus.umid  = u;
    bus.nivel = n;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset.rega", {30'd0, bus.rega}, 0);
    check("reset.alarme", {31'd0, bus.alarme}, 0);
    check("reset.n_regas", {24'd0, bus.n_regas}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] umid;
    logic [1:0] nivel;
    int         edges;
    logic [1:0] rega;
    logic       alarme;
    int         nreg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b11, 2'b11, 20, 2'b00, 1'b0, 0};
    vecs[1]  = '{2'b00, 2'b11,  6, 2'b00, 1'b0, 0};
    vecs[2]  = '{2'b00, 2'b11,  7, 2'b10, 1'b0, 1};
    vecs[3]  = '{2'b00, 2'b01,  6, 2'b00, 1'b0, 0};
    vecs[4]  = '{2'b00, 2'b01,  7, 2'b01, 1'b0, 1};
    vecs[5]  = '{2'b01, 2'b10,  7, 2'b01, 1'b0, 1};
    vecs[6]  = '{2'b01, 2'b11, 30, 2'b01, 1'b0, 1};
    vecs[7]  = '{2'b10, 2'b10, 15, 2'b00, 1'b0, 0};
    vecs[8]  = '{2'b11, 2'b00,  2, 2'b00, 1'b0, 0};
    vecs[9]  = '{2'b11, 2'b00,  3, 2'b00, 1'b1, 0};
    vecs[10] = '{2'b00, 2'b00, 25, 2'b00, 1'b1, 0};
    vecs[11] = '{2'b00, 2'b10, 40, 2'b10, 1'b0, 1};

    set_in(2'b11, 2'b11);
    do_reset();

    foreach (vecs[i]) begin
      set_in(2'b11, 2'b11);
      do_reset();
      set_in(vecs[i].umid, vecs[i].nivel);
      ticks(vecs[i].edges);
      check("vec.rega", {30'd0, bus.rega}, {30'd0, vecs[i].rega});
      check("vec.alarme", {31'd0, bus.alarme}, {31'd0, vecs[i].alarme});
      check("vec.n_regas", {24'd0, bus.n_regas}, vecs[i].nreg);
      $display("vec %0d: umid=%b nivel=%b edges=%0d -> rega=%b alarme=%b n_regas=%0d",
               i, vecs[i].umid, vecs[i].nivel, vecs[i].edges, bus.rega, bus.alarme, bus.n_regas);
    end

    // Glitch shorter than the debounce window.
    set_in(2'b11, 2'b11);
    do_reset();
    set_in(2'b00, 2'b11);
    ticks(3);
    set_in(2'b11, 2'b11);
    ticks(20);
    check("glitch.rega", {30'd0, bus.rega}, 0);
    check("glitch.n_regas", {24'd0, bus.n_regas}, 0);
    $display("seq glitch: rega=%b n_regas=%0d", bus.rega, bus.n_regas);

    // Minimum on-time defers an early exit from ASP.
    set_in(2'b11, 2'b11);
    do_reset();
    set_in(2'b00, 2'b11);
    ticks(7);
    check("minon.enter", {30'd0, bus.rega}, 2);
    set_in(2'b10, 2'b11);
    ticks(8);
    check("minon.hold15", {30'd0, bus.rega}, 2);
    tick();
    check("minon.exit16", {30'd0, bus.rega}, 0);
    check("minon.n_regas", {24'd0, bus.n_regas}, 1);
    $display("seq min_on: rega=%b n_regas=%0d", bus.rega, bus.n_regas);

    // Lockout from GOT, then recovery through NADA into ASP.
    set_in(2'b11, 2'b11);
    do_reset();
    set_in(2'b00, 2'b01);
    ticks(7);
    check("lock.got", {30'd0, bus.rega}, 1);
    set_in(2'b00, 2'b00);
    ticks(2);
    check("lock.k1.rega", {30'd0, bus.rega}, 1);
    check("lock.k1.alarme", {31'd0, bus.alarme}, 0);
    tick();
    check("lock.k2.rega", {30'd0, bus.rega}, 0);
    check("lock.k2.alarme", {31'd0, bus.alarme}, 1);
    set_in(2'b00, 2'b11);
    ticks(6);
    check("unlock.m5.alarme", {31'd0, bus.alarme}, 1);
    tick();
    check("unlock.m6.alarme", {31'd0, bus.alarme}, 0);
    check("unlock.m6.rega", {30'd0, bus.rega}, 0);
    tick();
    check("unlock.m7.rega", {30'd0, bus.rega}, 2);
    check("unlock.n_regas", {24'd0, bus.n_regas}, 2);
    $display("seq lockout: rega=%b alarme=%b n_regas=%0d", bus.rega, bus.alarme, bus.n_regas);

    // 256 irrigation entries wrap the counter.
    set_in(2'b11, 2'b11);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      int w;
      set_in(2'b00, 2'b11);
      w = 0;
      while (bus.rega != 2'b10 && w < 40) begin tick(); w++; end
      check("wrap.enter_timeout", (w < 40) ? 1 : 0, 1);
      set_in(2'b11, 2'b11);
      w = 0;
      while (bus.rega != 2'b00 && w < 40) begin tick(); w++; end
      check("wrap.exit_timeout", (w < 40) ? 1 : 0, 1);
      if (i == 254) check("wrap.n255", {24'd0, bus.n_regas}, 255);
    end
    check("wrap.n0", {24'd0, bus.n_regas}, 0);
    $display("seq wrap: n_regas=%0d after 256 entries", bus.n_regas);

    // Asynchronous reset in the middle of ASP.
    set_in(2'b11, 2'b11);
    do_reset();
    set_in(2'b00, 2'b11);
    ticks(10);
    check("midreset.asp", {30'd0, bus.rega}, 2);
    rst_n = 1'b0;
    #1;
    check("midreset.rega", {30'd0, bus.rega}, 0);
    check("midreset.n_regas", {24'd0, bus.n_regas}, 0);
    $display("seq mid_reset: rega=%b n_regas=%0d", bus.rega, bus.n_regas);
    set_in(2'b11, 2'b11);
    do_reset();

    // Random segments of held sensor values with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      logic [1:0] u, n;
      u = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) do_reset();
      set_in(u, n);
      ticks($urandom_range(1, 14));
    end
    $display("seq random: 300 segments, final rega=%b alarme=%b n_regas=%0d",
             bus.rega, bus.alarme, bus.n_regas);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rega_ctrl.md
# rega_ctrl

Irrigation request generator. It produces the 2-bit `rega` mode request (aspersão / gotejamento / nada) consumed by the irrigation mode state machine. It synchronizes and debounces the soil-moisture and tank-level sensors, then enforces a minimum irrigation on-time. An empty tank forces an immediate lockout with an alarm.

## Interface

- `DEB_CYCLES`, default 4: consecutive cycles a decision must hold before it is accepted (≥1).
- `MIN_ON`, default 8: minimum cycles `rega` stays at ASP or GOT before any non-lockout change (≥1).
- `CLK`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `umid`  in  2  soil moisture: 00 dry, 01 low, 10 ok, 11 wet; asynchronous to `CLK`.
- `nivel`  in  2  tank level: 00 empty, 01 low, 10/11 ok; asynchronous to `CLK`.
- `rega`  out  2  request: 00 NADA, 10 ASP (bit1 = aspersão), 01 GOT (bit0 = gotejamento); never 11.
- `alarme`  out  1  high while locked out for an empty tank.
- `n_regas`  out  8  count of entries into ASP or GOT; wraps 255→0.

## Operation

- Synchronizer: two flops per sensor bit (S1→S2). Reset value is `umid`=11, `nivel`=11.
- Candidate `cand`, combinational from S2, evaluated in priority order:
  - `nivel`=00 → VAZIO (11).
  - else `umid`=00 and `nivel`=1x → ASP.
  - else `umid`=00 and `nivel`=01 → GOT.
  - else `umid`=01 → GOT.
  - else NADA.
- Debounce registers are `cand_q` (reset NADA) and `cnt` (reset 0, saturates at `DEB_CYCLES`). On each edge:
  - if `cand`≠`cand_q`: `cand_q`←`cand`, `cnt`←1.
  - else if `cnt`<`DEB_CYCLES`: `cnt`++.
  - `stable` = (`cnt`==`DEB_CYCLES`).
- On-time counter `on_cnt`: cleared on entry to ASP/GOT, increments each edge in ASP/GOT, saturates at `MIN_ON`.
- States and `rega` / `alarme` per state:
  - NADA: 00 / 0.
  - ASP: 10 / 0.
  - GOT: 01 / 0.
  - TRAVA: 00 / 1.
  - Both outputs are registered state decodes.
- Transitions, highest priority first:
  - Any state, S2 `nivel`=00 → TRAVA. This bypasses the debounce and `MIN_ON`.
  - TRAVA: `stable` and `cand_q`≠VAZIO → NADA. It always passes through NADA first.
  - NADA: `stable` and `cand_q`∈{ASP,GOT} → `cand_q`.
  - ASP/GOT: `stable` and `cand_q`∉{VAZIO, current} and `on_cnt`==`MIN_ON` → `cand_q`. This covers direct ASP↔GOT and → NADA.
  - Otherwise the state holds.
- `n_regas` increments on the same edge that enters ASP or GOT, including direct ASP↔GOT.
- Unused state encodings recover to NADA on the next edge.

## Timing

- Reset asserted: immediately `rega`=00, `alarme`=0, `n_regas`=0, state NADA, `cand_q`=NADA, `cnt`=0, `on_cnt`=0.
- Deassertion is synchronous-safe: the first edge after release behaves as a normal edge.
- Normal latency: sensors steady before edge 1 → S2 valid after edge 2 → `cand_q` after edge 3 → `stable` after edge `DEB_CYCLES`+2 → `rega` changes at edge `DEB_CYCLES`+3 (edge 7 with defaults).
- Lockout latency: `nivel`=00 before edge k → `rega`=00 and `alarme`=1 from edge k+2.
- A candidate glitch shorter than `DEB_CYCLES` cycles at S2 never changes `rega`.
- `MIN_ON` holds: a debounced change that arrives early is deferred, not dropped. It applies on the first edge where `on_cnt`==`MIN_ON` and `stable` is still true.
- Reset mid-irrigation: `rega` returns to 00 asynchronously and all counters clear.

## Test plan

- Reset with `umid`=11, `nivel`=11 → `rega`=00, `alarme`=0, `n_regas`=0; values hold for 20 cycles after release.
- `umid`=00, `nivel`=11 before edge 1 → `rega`=10 from edge 7, `n_regas`=1. Same with `nivel`=01 → `rega`=01.
- `umid`=00 for 3 cycles, then 11 → `rega` stays 00, `n_regas` stays 0.
- Enter ASP at edge 7, then `umid`=10 before edge 8 → debounce is stable at edge 13, but `rega`=10 holds until `on_cnt` reaches 8 at edge 15 → `rega`=00 from edge 16.
- In GOT, `nivel`=00 before edge k → `rega`=00, `alarme`=1 at edge k+2, regardless of `on_cnt`. With `umid`=00 held, `nivel`=11 before edge m → `alarme`=0 and NADA at edge m+6, then `rega`=10 at edge m+7.
- Cycle NADA→ASP→NADA 256 times → `n_regas` wraps 255→0.
- Assert reset mid-ASP → `rega`=00 asynchronously.
